// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB master with wait-state timeout and held response
module apb_initiator #(
    parameter int TIMEOUT = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [2:0]  req_prot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        out_psel,
    output logic        out_penable,
    output logic        out_pwrite,
    output logic [31:0] out_paddr,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    output logic [2:0]  out_pprot,
    input  logic        out_pready,
    input  logic        out_pslverr,
    input  logic [31:0] out_prdata
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam bit HAS_TIMEOUT = TIMEOUT != 0;
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    state_t state;
    logic [15:0] wait_cnt;
    // Only IDLE accepts, and never while reset is being applied
    assign req_ready = state == IDLE && !reset;
    // Transfer sequencer; APB and response outputs are all registered here
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            out_pwrite  <= 1'b0;
            out_paddr   <= '0;
            out_pwdata  <= '0;
            out_pstrb   <= '0;
            out_pprot   <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    out_psel   <= 1'b1;
                    out_pwrite <= req_write;
                    out_paddr  <= req_addr;
                    out_pprot  <= req_prot;
                    out_pwdata <= req_write ? req_wdata : '0;
                    out_pstrb  <= req_write ? req_wstrb : '0;
                    state      <= SETUP;
                end
                SETUP: begin
                    out_penable <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end
                ACCESS: if (out_pready) begin
                    out_psel    <= 1'b0;
                    out_penable <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= out_pwrite ? '0 : out_prdata;
                    rsp_err     <= out_pslverr;
                    rsp_timeout <= 1'b0;
                    state       <= RESP;
                end else if (HAS_TIMEOUT && wait_cnt == LAST_WAIT) begin
                    out_psel    <= 1'b0;
                    out_penable <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                    state       <= RESP;
                end else if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: directed and randomized transfers against a transaction-level model
module tb_apb_initiator;
    localparam int TO = 4;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic [2:0]  req_prot = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        out_psel, out_penable, out_pwrite;
    logic [31:0] out_paddr, out_pwdata;
    logic [3:0]  out_pstrb;
    logic [2:0]  out_pprot;
    logic        out_pready = 1'b0, out_pslverr = 1'b0;
    logic [31:0] out_prdata = '0;
    int checks = 0;
    int passed = 0;

    apb_initiator #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
        .out_paddr(out_paddr), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb), .out_pprot(out_pprot),
        .out_pready(out_pready), .out_pslverr(out_pslverr), .out_prdata(out_prdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic scramble_req(input bit v);
        req_valid = v;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        req_prot  = 3'($urandom);
    endtask

    task automatic chk_attr(input bit w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] st, input logic [2:0] pr);
        chk("pwrite", out_pwrite, w);
        chk("paddr", out_paddr, a);
        chk("pprot", out_pprot, pr);
        chk("pwdata", out_pwdata, w ? wd : 32'h0);
        chk("pstrb", out_pstrb, w ? st : 4'h0);
    endtask

    // waits = pready-low ACCESS cycles before pready; hold = cycles rsp_ready stays low;
    // rst_at = ACCESS cycle index on which reset is pulsed (-1 for none)
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int waits,
                        input logic [31:0] rd, input bit se, input int hold, input int rst_at);
        bit to;
        int n;
        to = waits >= TO;
        n  = to ? TO : waits + 1;
        chk("idle_ready", req_ready, 1);
        chk("idle_psel", out_psel, 0);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_wstrb = st; req_prot = pr;
        @(negedge clock);
        scramble_req(1'b1);
        out_pready = 1'b1; out_pslverr = 1'b1; out_prdata = $urandom;
        chk("setup_psel", out_psel, 1);
        chk("setup_penable", out_penable, 0);
        chk("setup_ready", req_ready, 0);
        chk_attr(w, a, wd, st, pr);
        @(negedge clock);
        for (int k = 0; k < n; k++) begin
            chk("access_psel", out_psel, 1);
            chk("access_penable", out_penable, 1);
            chk("access_rsp_valid", rsp_valid, 0);
            chk_attr(w, a, wd, st, pr);
            scramble_req(1'($urandom));
            if (k == rst_at) begin
                reset = 1'b1; req_valid = 1'b0; out_pready = 1'b1;
                @(negedge clock);
                chk("rst_psel", out_psel, 0);
                chk("rst_penable", out_penable, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_ready", req_ready, 0);
                chk("rst_paddr", out_paddr, 0);
                reset = 1'b0; out_pready = 1'b0;
                @(negedge clock);
                chk("rst_after_ready", req_ready, 1);
                chk("rst_after_rsp_valid", rsp_valid, 0);
                return;
            end
            out_pready  = !to && k == waits;
            out_prdata  = (k == waits) ? rd : $urandom;
            out_pslverr = (k == waits) ? se : 1'($urandom);
            @(negedge clock);
        end
        out_pready = 1'b1; out_pslverr = 1'b1; out_prdata = $urandom;
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, (to || w) ? 32'h0 : rd);
            chk("rsp_err", rsp_err, to ? 1'b1 : se);
            chk("rsp_timeout", rsp_timeout, to);
            chk("resp_psel", out_psel, 0);
            chk("resp_penable", out_penable, 0);
            chk("resp_ready", req_ready, 0);
            rsp_ready = h == hold;
            scramble_req(h != hold);
            @(negedge clock);
        end
        rsp_ready = 1'b0; out_pready = 1'b0; out_pslverr = 1'b0;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_psel", out_psel, 0);
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        chk("reset_ready", req_ready, 0);
        chk("reset_psel", out_psel, 0);
        chk("reset_penable", out_penable, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_rsp_timeout", rsp_timeout, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_paddr", out_paddr, 0);
        chk("reset_pwdata", out_pwdata, 0);
        chk("reset_pstrb", out_pstrb, 0);
        chk("reset_pwrite", out_pwrite, 0);
        chk("reset_pprot", out_pprot, 0);
        reset = 1'b0;
        @(negedge clock);
        xfer(1'b0, 32'h1000_0004, 32'h0, 4'h0, 3'd0, 0, 32'hDEAD_BEEF, 1'b0, 0, -1);
        xfer(1'b1, 32'h2000_0010, 32'h0000_00A5, 4'b0001, 3'd2, 3, 32'h1234_5678, 1'b0, 0, -1);
        xfer(1'b0, 32'h3000_0000, 32'h0, 4'h0, 3'd1, 1, 32'hCAFE_F00D, 1'b1, 0, -1);
        xfer(1'b0, 32'h4000_0008, 32'h0, 4'h0, 3'd0, 9, 32'h5555_AAAA, 1'b0, 0, -1);
        xfer(1'b1, 32'h5000_000C, 32'h0BAD_0BAD, 4'b0000, 3'd7, 0, 32'h0, 1'b0, 0, -1);
        xfer(1'b0, 32'h6000_0000, 32'h0, 4'h0, 3'd3, 0, 32'h0F0F_0F0F, 1'b0, 5, -1);
        xfer(1'b1, 32'h7000_0004, 32'h1111_2222, 4'hF, 3'd0, 5, 32'h0, 1'b0, 0, 1);
        xfer(1'b0, 32'h8000_0000, 32'h0, 4'h0, 3'd0, 0, 32'h9876_5432, 1'b0, 0, -1);
        for (int i = 0; i < 25; i++)
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                 int'($urandom_range(0, 6)), $urandom, 1'($urandom), int'($urandom_range(0, 3)), -1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning max ACCESS cycles awaiting out_pready; 0 = wait forever; legal range 0..65535.
REQ-002 SHALL have port clock  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  upstream request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready.
REQ-006 SHALL have ports req_write (input, 1), req_addr (input, 32), req_wdata (input, 32), req_wstrb (input, 4), req_prot (input, 3); each is the request attribute, sampled only at acceptance.
REQ-007 SHALL have port rsp_valid  output  1  response present.
REQ-008 SHALL have port rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
REQ-009 SHALL have ports rsp_rdata (output, 32), rsp_err (output, 1), rsp_timeout (output, 1); read data, slave error or timeout, and timeout only, respectively.
REQ-010 SHALL have ports out_psel, out_penable, out_pwrite (output, 1 each), out_paddr (output, 32), out_pwdata (output, 32), out_pstrb (output, 4), out_pprot (output, 3): APB initiator outputs.
REQ-011 SHALL have ports out_pready, out_pslverr (input, 1 each) and out_prdata (input, 32): APB responder returns.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded from state only, with no combinational path from req_* or out_* inputs to any output.
REQ-013 SHALL drive req_ready=1 only in IDLE; acceptance latches the req_* fields and moves to SETUP.
REQ-014 SETUP SHALL last exactly one cycle: out_psel=1, out_penable=0, then go to ACCESS.
REQ-015 ACCESS SHALL drive out_psel=1, out_penable=1 and hold until out_pready=1 or timeout.
REQ-016 out_paddr, out_pwrite, out_pprot, out_pwdata, out_pstrb SHALL come from the latched request and stay constant from SETUP through the last ACCESS cycle.
REQ-017 For reads, out_pstrb SHALL be 4'b0000 and out_pwdata 0; for writes, out_pstrb=req_wstrb, including all-zero strobes passed unchanged.
REQ-018 On an ACCESS cycle with out_pready=1, SHALL capture rsp_rdata=out_prdata (reads) or 0 (writes), rsp_err=out_pslverr, rsp_timeout=0, and go to RESP.
REQ-019 A 16-bit wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with out_pready=0.
REQ-020 If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with out_pready=0, SHALL go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0; the counter saturates and does not wrap.
REQ-021 out_psel and out_penable SHALL be 0 in IDLE and RESP; the transfer always ends at the ACCESS exit edge.
REQ-022 RESP SHALL drive rsp_valid=1 with stable rsp_* until rsp_ready=1, then go to IDLE.
REQ-023 Minimum cost per transfer with zero wait states and rsp_ready=1 SHALL be 4 cycles: accept, SETUP, ACCESS, RESP; the next request is accepted in the following IDLE cycle.
REQ-024 out_pready and out_pslverr SHALL be ignored outside ACCESS.
REQ-025 Changes on req_* while not in IDLE SHALL have no effect.

Reset
REQ-026 While reset=1 at a clock edge, SHALL enter IDLE and set out_psel=0, out_penable=0, rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0, out_paddr=0, out_pwdata=0, out_pstrb=0, out_pwrite=0, out_pprot=0, counter=0; req_ready=0 during reset.
REQ-027 Reset asserted mid-transfer (SETUP, ACCESS or RESP) SHALL abort it: psel/penable low after that edge, no response is issued, and the latched request is discarded.

Verification
REQ-028 Read, zero wait: req addr=0x1000_0004, out_pready=1 in ACCESS, prdata=0xDEADBEEF -> psel high for 2 cycles, penable high for 1, rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after acceptance.
REQ-029 Write, 3 wait states: wdata=0x0000_00A5, wstrb=4'b0001 -> pwdata/pstrb/paddr stable across 4 ACCESS cycles, out_pwrite=1, rsp_rdata=0, rsp_err=0.
REQ-030 Slave error: out_pslverr=1 with pready on a read -> rsp_err=1, rsp_timeout=0.
REQ-031 Timeout, TIMEOUT=4, pready stuck 0 -> exactly 4 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel=0.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data held, req_ready=0, no new APB activity; rsp_ready=1 -> IDLE next cycle.
REQ-033 Reset in ACCESS: reset pulsed on 2nd wait cycle -> psel/penable=0 next edge, no rsp_valid, and a subsequent request completes normally.
